divider: RTL and testbench

- Iterative radix-2 restoring integer divider for the CPU's DIV/DIVU path.
- It is the inverse-operation companion of the pipelined multiplier and uses the same op encoding and the same done-level handshake.
- Produces quotient (LO) and remainder (HI).
- The core issues one op while done=1, then stalls on done.

---
 rtl/cpu_arith_pkg.sv | 16 +
 rtl/divider_if.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/divider.sv | 76 +++++++
 tb/tb_divider.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_arith_pkg.sv
// Arithmetic definitions shared by the CPU multiplier and divider:
// the operation encoding and the default datapath width.
package cpu_arith_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_NONE     = 2'b00,
    OP_UNSIGNED = 2'b01,
    OP_SIGNED   = 2'b10,
    OP_RSVD     = 2'b11
  } arith_op_t;

  localparam int unsigned ARITH_OP_BITS = $bits(arith_op_t);

endpackage

// File: rtl/divider_if.sv
// Core-to-divider handshake: the core issues an op while done=1 and then
// reads quotient/remainder once done has risen again.
interface divider_if
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
);
  arith_op_t          op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               done;

  modport master (output op, a, b, input quotient, remainder, done);
  modport slave  (input op, a, b, output quotient, remainder, done);
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one bit, subtract the
// divisor from the partial remainder and keep the difference if it is >= 0.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The extra top bit makes the borrow of the trial subtraction visible as a sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {2'b00, divisor};

  always_comb begin
    // NOTE: combinational blocks assign every output first so no path can
    // leave a stale value behind, which would otherwise infer a latch.
    rem_next = shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_next    = trial[WIDTH:0];
      quo_next[0] = 1'b1;
    end
  end
endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per
// cycle, constant ITER-cycle latency, signs restored on the outputs.
module divider
  import cpu_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int ITER  = WIDTH
) (
  input logic       clk,
  input logic       rst,
  divider_if.slave  bus
);
  localparam int CW = $clog2(ITER + 1);

  logic [CW-1:0]    counter;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             qsign;
  logic             rsign;
  logic             dz;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             is_signed;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_signed = (bus.op == OP_SIGNED);
  assign accept    = bus.done && (bus.op == OP_SIGNED || bus.op == OP_UNSIGNED);

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (div_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      div_mag <= '0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      dz      <= 1'b0;
    end else if (accept) begin
      counter <= CW'(ITER);
      rem     <= '0;
      quo     <= a_mag;
      div_mag <= b_mag;
      qsign   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      rsign   <= is_signed && bus.a[WIDTH-1];
      dz      <= (bus.b == '0);
    end else if (counter != '0) begin
      rem     <= rem_next;
      quo     <= quo_next;
      counter <= counter - CW'(1);
    end
  end

  // A zero divisor lets every trial succeed, so rem ends equal to |a| and the
  // sign restoration below returns the original dividend unchanged.
  assign bus.done      = (counter == '0);
  assign bus.quotient  = dz ? '1 : (qsign ? -quo : quo);
  assign bus.remainder = rsign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vector table, multi-cycle
// corner sequences and random ops checked against an arithmetic model.
module tb_divider;
  import cpu_arith_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  divider_if #(.WIDTH(W)) dif ();

  divider #(.WIDTH(W), .ITER(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  typedef struct {
    string       name;
    arith_op_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, computed wide
  // enough that the signed overflow case wraps naturally.
  function automatic void model(input arith_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == OP_SIGNED) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issues one op and waits for done. kind=1 presents a second op mid-flight.
  task automatic run_op(input arith_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int kind, output logic [31:0] q, output logic [31:0] r,
                        output int lat);
    @(negedge clk);
    dif.op = op;
    dif.a  = a;
    dif.b  = b;
    @(negedge clk);
    dif.op = OP_NONE;
    dif.a  = $urandom;
    dif.b  = $urandom;
    lat = 0;
    while (!dif.done && lat < 100) begin
      lat++;
      if (kind == 1 && lat == 5) begin
        dif.op = OP_UNSIGNED;
        dif.a  = 32'd9;
        dif.b  = 32'd3;
      end else if (kind == 1 && lat == 6) begin
        dif.op = OP_NONE;
      end
      @(negedge clk);
    end
    q = dif.quotient;
    r = dif.remainder;
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    int          lat;
    arith_op_t   rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"u100_7",     OP_UNSIGNED, 32'd100,      32'd7,        32'd14,       32'd2};
    vecs[1] = '{"s-7_2",      OP_SIGNED,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{"s7_-2",      OP_SIGNED,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{"s_ovf",      OP_SIGNED,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[4] = '{"u_max_1",    OP_UNSIGNED, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[5] = '{"u_dz",       OP_UNSIGNED, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
    vecs[6] = '{"s_dz",       OP_SIGNED,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[7] = '{"u0_5",       OP_UNSIGNED, 32'd0,        32'd5,        32'd0,        32'd0};
    vecs[8] = '{"s_min_2",    OP_SIGNED,   32'h80000000, 32'd2,        32'hC0000000, 32'd0};

    dif.op = OP_NONE;
    dif.a  = '0;
    dif.b  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_done", {31'd0, dif.done}, 32'd1);
    check("reset_q", dif.quotient, 32'd0);
    check("reset_r", dif.remainder, 32'd0);

    // Reserved op while idle must not start anything.
    dif.op = OP_RSVD;
    dif.a  = 32'd50;
    dif.b  = 32'd5;
    @(negedge clk);
    dif.op = OP_NONE;
    check("op11_done", {31'd0, dif.done}, 32'd1);
    check("op11_q", dif.quotient, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, q, r, lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'd32);
      check({vecs[i].name, "_q"}, q, vecs[i].q);
      check({vecs[i].name, "_r"}, r, vecs[i].r);
    end

    // Results hold while the core presents no op.
    run_op(OP_UNSIGNED, 32'd100, 32'd7, 0, q, r, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_done", {31'd0, dif.done}, 32'd1);
      check("hold_q", dif.quotient, 32'd14);
      check("hold_r", dif.remainder, 32'd2);
    end

    // An op presented while busy is dropped and does not disturb timing.
    run_op(OP_UNSIGNED, 32'd100, 32'd7, 1, q, r, lat);
    check("busy_lat", 32'(lat), 32'd32);
    check("busy_q", q, 32'd14);
    check("busy_r", r, 32'd2);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    dif.op = OP_UNSIGNED;
    dif.a  = 32'd1000;
    dif.b  = 32'd3;
    @(negedge clk);
    dif.op = OP_NONE;
    repeat (9) @(negedge clk);
    check("midrst_busy", {31'd0, dif.done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_done", {31'd0, dif.done}, 32'd1);
    check("midrst_q", dif.quotient, 32'd0);
    check("midrst_r", dif.remainder, 32'd0);
    run_op(OP_UNSIGNED, 32'd9, 32'd3, 0, q, r, lat);
    check("after_rst_lat", 32'(lat), 32'd32);
    check("after_rst_q", q, 32'd3);
    check("after_rst_r", r, 32'd0);

    // Reset and a valid op on the same edge: the op is dropped.
    @(negedge clk);
    rst    = 1'b1;
    dif.op = OP_SIGNED;
    dif.a  = 32'd77;
    dif.b  = 32'd7;
    @(negedge clk);
    rst    = 1'b0;
    dif.op = OP_NONE;
    check("rst_op_done", {31'd0, dif.done}, 32'd1);
    check("rst_op_q", dif.quotient, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(1) == 0) ? OP_UNSIGNED : OP_SIGNED;
      ra  = $urandom;
      case ($urandom_range(4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(15));
        2:       rb = -32'($urandom_range(15));
        default: rb = $urandom >> $urandom_range(31);
      endcase
      model(rop, ra, rb, eq, er);
      run_op(rop, ra, rb, 0, q, r, lat);
      check("rand_lat", 32'(lat), 32'd32);
      check("rand_q", q, eq);
      check("rand_r", r, er);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
